// File: rtl/pixel_batch_scheduler_pkg.sv
// Shared types and sizing helpers for the pixel batch scheduler.
// Used by the scheduler FSM, its position counter and display-side logic.
package pixel_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COMPUTE
  } sched_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int batches_per_line(
    input int h_res,
    input int num_pixels
  );
    return h_res / num_pixels;
  endfunction

endpackage

// File: rtl/pixel_batch_scheduler_if.sv
// Processor and scan-out FIFO signals driven/consumed by the scheduler.
// master = scheduler side, slave = processor/FIFO side.
interface pixel_batch_scheduler_if #(
  parameter int RESULT_WIDTH = 96
) ();

  logic                    new_frame;
  logic                    start_next_batch;
  logic [RESULT_WIDTH-1:0] result;
  logic                    result_ready;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [RESULT_WIDTH-1:0] fifo_wr_data;

  modport master (
    output new_frame,
    output start_next_batch,
    input  result,
    input  result_ready,
    input  fifo_full,
    output fifo_wr_en,
    output fifo_wr_data
  );

  modport slave (
    input  new_frame,
    input  start_next_batch,
    output result,
    output result_ready,
    output fifo_full,
    input  fifo_wr_en,
    input  fifo_wr_data
  );

endinterface

// File: rtl/pixel_batch_scheduler_counter.sv
// Nested batch-within-line / line-within-frame position counter.
// Wraps fully after the last batch of the last line.
module batch_position_counter
  import pixel_sched_pkg::*;
#(
  parameter int BATCHES = 80,
  parameter int LINES   = 480
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      advance,
  output logic [cnt_w(BATCHES)-1:0] batch,
  output logic [cnt_w(LINES)-1:0]   line,
  output logic                      last_of_frame
);

  localparam int BW = cnt_w(BATCHES);
  localparam int LW = cnt_w(LINES);
  localparam logic [BW-1:0] B_LAST = BW'(BATCHES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LINES - 1);

  logic end_of_line;

  assign end_of_line   = (batch == B_LAST);
  assign last_of_frame = end_of_line && (line == L_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      batch <= '0;
      line  <= '0;
    end else if (clear) begin
      batch <= '0;
      line  <= '0;
    end else if (advance) begin
      if (end_of_line) begin
        batch <= '0;
        line  <= (line == L_LAST) ? '0 : line + 1'b1;
      end else begin
        batch <= batch + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_batch_scheduler.sv
// Sequences pixel_processor batches over a frame and feeds the scan-out FIFO.
// All handshake outputs are registered pulses.
module pixel_batch_scheduler
  import pixel_sched_pkg::*;
#(
  parameter int NUM_PIXELS   = 8,
  parameter int PIXEL_WIDTH  = 12,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int RESULT_WIDTH = NUM_PIXELS * PIXEL_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic frame_start,
  pixel_batch_scheduler_if.master bus,
  output logic busy,
  output logic frame_done,
  output logic frame_overrun,
  output logic [cnt_w(H_RES/NUM_PIXELS)-1:0] cur_batch,
  output logic [cnt_w(V_RES)-1:0]            cur_line
);

  localparam int BPL = batches_per_line(H_RES, NUM_PIXELS);

  sched_state_e state_q, state_d;

  logic nf_d, snb_d, wr_d, fd_d;
  logic ov_set, clr, adv, last, write_ok;
  logic nf_q, snb_q, wr_q, fd_q, ov_q;
  logic [RESULT_WIDTH-1:0] data_q;

  batch_position_counter #(
    .BATCHES (BPL),
    .LINES   (V_RES)
  ) u_pos (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (clr),
    .advance       (adv),
    .batch         (cur_batch),
    .line          (cur_line),
    .last_of_frame (last)
  );

  assign write_ok = bus.result_ready && !bus.fifo_full;

  always_comb begin
    state_d = state_q;
    nf_d    = 1'b0;
    snb_d   = 1'b0;
    wr_d    = 1'b0;
    fd_d    = 1'b0;
    ov_set  = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start && enable) begin
          nf_d    = 1'b1;
          clr     = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        // result_ready is stale here; the processor has not seen our pulse
        state_d = COMPUTE;
        if (frame_start) begin
          ov_set  = 1'b1;
          nf_d    = 1'b1;
          clr     = 1'b1;
          state_d = ARM;
        end
      end
      COMPUTE: begin
        if (write_ok && last) begin
          wr_d    = 1'b1;
          fd_d    = 1'b1;
          adv     = 1'b1;
          state_d = IDLE;
          if (frame_start && enable) begin
            nf_d    = 1'b1;
            clr     = 1'b1;
            state_d = ARM;
          end
        end else if (frame_start) begin
          ov_set  = 1'b1;
          nf_d    = 1'b1;
          clr     = 1'b1;
          state_d = ARM;
        end else if (write_ok) begin
          wr_d    = 1'b1;
          adv     = 1'b1;
          snb_d   = 1'b1;
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      nf_q    <= 1'b0;
      snb_q   <= 1'b0;
      wr_q    <= 1'b0;
      fd_q    <= 1'b0;
      ov_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      nf_q    <= nf_d;
      snb_q   <= snb_d;
      wr_q    <= wr_d;
      fd_q    <= fd_d;
      if (ov_set) ov_q <= 1'b1;
      if (wr_d) data_q <= bus.result;
    end
  end

  assign bus.new_frame        = nf_q;
  assign bus.start_next_batch = snb_q;
  assign bus.fifo_wr_en       = wr_q;
  assign bus.fifo_wr_data     = data_q;
  assign busy                 = (state_q != IDLE);
  assign frame_done           = fd_q;
  assign frame_overrun        = ov_q;

endmodule

// File: tb/tb_pixel_batch_scheduler.sv
// Scoreboard bench for pixel_batch_scheduler on a 16x2 frame,
// with a behavioural 16-cycle pixel_processor model.
module tb_pixel_batch_scheduler;

  localparam int NP  = 8;
  localparam int PW  = 12;
  localparam int RW  = NP * PW;
  localparam int LAT = 16;

  typedef struct {
    logic [RW-1:0] data;
    logic          done;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst_n;
  logic proc_rst_n;
  logic enable;
  logic frame_start;
  logic fifo_full;
  logic busy, frame_done, frame_overrun;
  logic cur_batch, cur_line;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_wr = 0, cnt_snb = 0, cnt_nf = 0, cnt_done = 0;
  int pc;
  logic [PW-1:0] seq;
  logic full_at_edge;
  sb_item_t sb[$];
  sb_item_t mon_item;

  pixel_batch_scheduler_if #(.RESULT_WIDTH(RW)) bus ();

  pixel_batch_scheduler #(
    .NUM_PIXELS  (NP),
    .PIXEL_WIDTH (PW),
    .H_RES       (16),
    .V_RES       (2)
  ) dut (
    .clk           (clk),
    .reset_n       (rst_n),
    .enable        (enable),
    .frame_start   (frame_start),
    .bus           (bus),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .cur_batch     (cur_batch),
    .cur_line      (cur_line)
  );

  always #5 clk = ~clk;

  // processor model: result_ready rises LAT cycles after a start
  always @(posedge clk) begin
    if (!proc_rst_n) begin
      pc  <= LAT;
      seq <= '0;
    end else if (bus.new_frame || bus.start_next_batch) begin
      pc  <= 0;
      seq <= seq + 1'b1;
    end else if (pc != LAT) begin
      pc <= pc + 1;
    end
  end

  assign bus.result_ready = proc_rst_n && (pc == LAT);
  assign bus.result       = {NP{seq}};
  assign bus.fifo_full    = fifo_full;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int s, input logic d);
    logic [PW-1:0] v;
    sb_item_t it;
    v = s[PW-1:0];
    it.data = {NP{v}};
    it.done = d;
    sb.push_back(it);
  endtask

  always @(posedge clk) full_at_edge = fifo_full;

  always @(negedge clk) begin
    if (rst_n) begin
      cnt_wr   += int'(bus.fifo_wr_en);
      cnt_snb  += int'(bus.start_next_batch);
      cnt_nf   += int'(bus.new_frame);
      cnt_done += int'(frame_done);
    end
  end

  // monitor: every FIFO write is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("nf_with_snb",
          bus.new_frame & bus.start_next_batch, 0);
      if (bus.fifo_wr_en) begin
        chk("wr_while_full", full_at_edge, 0);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_item = sb.pop_front();
          chk("wr_data", bus.fifo_wr_data, mon_item.data);
          chk("done_flag", frame_done, mon_item.done);
        end
      end else begin
        chk("done_no_write", frame_done, 0);
      end
    end
  end

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_decide(input bit allow_full);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.result_ready && busy &&
          !bus.new_frame && !bus.start_next_batch &&
          (allow_full || !bus.fifo_full)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("decide_timeout", ok, 1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", ok, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int b_wr, b_snb, b_nf, b_done;
    rst_n       = 1'b0;
    proc_rst_n  = 1'b0;
    enable      = 1'b1;
    frame_start = 1'b0;
    fifo_full   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_outs", {bus.new_frame, bus.start_next_batch,
        bus.fifo_wr_en, frame_done, frame_overrun,
        cur_batch, cur_line}, 0);
    chk("reset_data", bus.fifo_wr_data, 0);
    rst_n      = 1'b1;
    proc_rst_n = 1'b1;

    // frame 1: plain frame, stale ready across each start
    push(1, 0); push(2, 0); push(3, 0); push(4, 1);
    b_wr = cnt_wr; b_snb = cnt_snb;
    b_nf = cnt_nf; b_done = cnt_done;
    start_frame();
    chk("f1_new_frame", bus.new_frame, 1);
    for (int i = 0; i < 4; i++) begin
      wait_decide(0);
      chk("f1_pos", {cur_line, cur_batch}, i);
      if (i < 3) begin
        @(negedge clk);
        chk("f1_stale_arm",
            bus.result_ready & bus.start_next_batch, 1);
      end
    end
    wait_done();
    @(posedge clk);
    chk("f1_writes", cnt_wr - b_wr, 4);
    chk("f1_starts", cnt_snb - b_snb, 3);
    chk("f1_nf", cnt_nf - b_nf, 1);
    chk("f1_done", cnt_done - b_done, 1);

    // frame 2: FIFO full for 20 cycles with ready held high
    push(5, 0); push(6, 0); push(7, 0); push(8, 1);
    @(negedge clk);
    fifo_full = 1'b1;
    start_frame();
    wait_decide(1);
    b_wr = cnt_wr; b_snb = cnt_snb;
    repeat (20) @(negedge clk);
    chk("bp_ready_held", bus.result_ready, 1);
    chk("bp_no_write", cnt_wr - b_wr, 0);
    chk("bp_no_start", cnt_snb - b_snb, 0);
    fifo_full = 1'b0;
    @(negedge clk);
    chk("bp_write_next", bus.fifo_wr_en, 1);
    wait_done();

    // frame 3 -> 4: frame_start lands on the final write
    push(9, 0); push(10, 0); push(11, 0); push(12, 1);
    push(13, 0); push(14, 0); push(15, 0); push(16, 1);
    start_frame();
    for (int i = 0; i < 4; i++) wait_decide(0);
    chk("b2b_pos", {cur_line, cur_batch}, 3);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("b2b_nf", bus.new_frame, 1);
    chk("b2b_wr", bus.fifo_wr_en, 1);
    chk("b2b_done", frame_done, 1);
    chk("b2b_no_ovr", frame_overrun, 0);
    wait_done();
    chk("b2b_ovr_after", frame_overrun, 0);

    // frame 5: overrun at the third batch
    push(17, 0); push(18, 0);
    push(20, 0); push(21, 0); push(22, 0); push(23, 1);
    start_frame();
    for (int i = 0; i < 3; i++) wait_decide(0);
    chk("ovr_pos", {cur_line, cur_batch}, 2);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("ovr_flag", frame_overrun, 1);
    chk("ovr_nf", bus.new_frame, 1);
    chk("ovr_no_wr", bus.fifo_wr_en, 0);
    chk("ovr_no_snb", bus.start_next_batch, 0);
    chk("ovr_pos_clr", {cur_line, cur_batch}, 0);
    b_wr = cnt_wr; b_done = cnt_done;
    wait_done();
    @(posedge clk);
    chk("ovr_writes", cnt_wr - b_wr, 4);
    chk("ovr_done", cnt_done - b_done, 1);
    chk("ovr_sticky", frame_overrun, 1);

    // frame 6: async reset while computing
    start_frame();
    repeat (5) @(negedge clk);
    chk("rst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ovr", frame_overrun, 0);
    chk("rst_data", bus.fifo_wr_data, 0);
    chk("rst_outs", {bus.new_frame, bus.start_next_batch,
        bus.fifo_wr_en, frame_done, cur_batch, cur_line}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b0;
    b_nf = cnt_nf;
    start_frame();
    repeat (5) @(negedge clk);
    @(posedge clk);
    chk("dis_no_nf", cnt_nf - b_nf, 0);
    chk("dis_idle", busy, 0);

    // frame 7: restart after reset
    enable = 1'b1;
    push(25, 0); push(26, 0); push(27, 0); push(28, 1);
    start_frame();
    chk("rs_nf", bus.new_frame, 1);
    wait_done();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
